// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, FSM state type and counter-width helper for the
// parametrised VGA timing generator.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef enum logic {
        WAIT_FILL = 1'b0,
        RUN       = 1'b1
    } vga_state_e;

    // A total of 1 still needs a one-bit counter.
    function automatic int unsigned cnt_w(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical position counters with wrap detection and decode of
// the active area and the two sync windows.
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            run_i,
    output logic [cnt_w(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]     h_cnt_o,
    output logic [cnt_w(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]     v_cnt_o,
    output logic                                            active_o,
    output logic                                            h_win_o,
    output logic                                            v_win_o,
    output logic                                            frame_end_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W     = cnt_w(H_TOTAL);
    localparam int unsigned V_W     = cnt_w(V_TOTAL);

    logic [H_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_W-1:0] v_cnt_q, v_cnt_d;
    logic           h_last, v_last;

    assign h_last = (32'(h_cnt_q) == H_TOTAL - 1);
    assign v_last = (32'(v_cnt_q) == V_TOTAL - 1);

    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (run_i) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + V_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + H_W'(1);
                v_cnt_d = v_cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o     = h_cnt_q;
    assign v_cnt_o     = v_cnt_q;
    assign active_o    = run_i && (32'(h_cnt_q) < H_ACTIVE) && (32'(v_cnt_q) < V_ACTIVE);
    // Windows are half-open: [ACTIVE+FP, ACTIVE+FP+SYNC).
    assign h_win_o     = run_i && (32'(h_cnt_q) >= H_ACTIVE + H_FP)
                               && (32'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC);
    assign v_win_o     = run_i && (32'(v_cnt_q) >= V_ACTIVE + V_FP)
                               && (32'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC);
    assign frame_end_o = run_i && h_last && v_last;

endmodule

// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA timing generator: pulls pixels from a show-ahead FIFO and
// drives registered colour, syncs, blanking, coordinates and frame markers.
module vga_timing_gen_param
    import vga_timing_pkg::*;
#(
    parameter int unsigned COLOR_W        = 8,
    parameter int unsigned H_ACTIVE       = DEF_H_ACTIVE,
    parameter int unsigned H_FP           = DEF_H_FP,
    parameter int unsigned H_SYNC         = DEF_H_SYNC,
    parameter int unsigned H_BP           = DEF_H_BP,
    parameter int unsigned V_ACTIVE       = DEF_V_ACTIVE,
    parameter int unsigned V_FP           = DEF_V_FP,
    parameter int unsigned V_SYNC         = DEF_V_SYNC,
    parameter int unsigned V_BP           = DEF_V_BP,
    parameter logic        HSYNC_POL      = 1'b0,
    parameter logic        VSYNC_POL      = 1'b0,
    parameter int unsigned UNDERFLOW_MODE = 0
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            fifo_empty,
    input  logic [3*COLOR_W-1:0]                            fifo_data,
    output logic                                            fifo_rreq,
    input  logic                                            clr_underflow,
    output logic [COLOR_W-1:0]                              red,
    output logic [COLOR_W-1:0]                              green,
    output logic [COLOR_W-1:0]                              blue,
    output logic                                            hsync,
    output logic                                            vsync,
    output logic                                            sync_n,
    output logic                                            blank_n,
    output logic [cnt_w(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]     pixel_x,
    output logic [cnt_w(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]     pixel_y,
    output logic                                            frame_start,
    output logic                                            underflow,
    output logic [15:0]                                     frame_count
);

    localparam int unsigned PX_W = cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int unsigned PY_W = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int unsigned RGB_W = 3 * COLOR_W;

    vga_state_e state_q, state_d;

    logic [PX_W-1:0]  h_cnt;
    logic [PY_W-1:0]  v_cnt;
    logic             run, active, h_win, v_win, frame_end;

    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic [RGB_W-1:0] hold_q, hold_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             sync_n_q, sync_n_d;
    logic             blank_n_q, blank_n_d;
    logic [PX_W-1:0]  pixel_x_q, pixel_x_d;
    logic [PY_W-1:0]  pixel_y_q, pixel_y_d;
    logic             frame_start_q, frame_start_d;
    logic             underflow_q, underflow_d;
    logic [15:0]      frame_count_q, frame_count_d;

    assign run = (state_q == RUN);

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_cnt (
        .clk         (clk),
        .rst_n       (rst),
        .run_i       (run),
        .h_cnt_o     (h_cnt),
        .v_cnt_o     (v_cnt),
        .active_o    (active),
        .h_win_o     (h_win),
        .v_win_o     (v_win),
        .frame_end_o (frame_end)
    );

    always_comb begin
        state_d = state_q;
        if (state_q == WAIT_FILL && !fifo_empty) begin
            state_d = RUN;
        end
    end

    assign fifo_rreq = active && !fifo_empty;

    always_comb begin
        rgb_d         = '0;
        hold_d        = hold_q;
        underflow_d   = underflow_q;
        if (active && !fifo_empty) begin
            rgb_d  = fifo_data;
            hold_d = fifo_data;
        end else if (active) begin
            rgb_d = (UNDERFLOW_MODE != 0) ? hold_q : '0;
        end
        // A new underflow wins over a clear in the same cycle.
        if (active && fifo_empty) begin
            underflow_d = 1'b1;
        end else if (clr_underflow) begin
            underflow_d = 1'b0;
        end

        hsync_d       = h_win ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = v_win ? VSYNC_POL : ~VSYNC_POL;
        sync_n_d      = hsync_d ^ vsync_d;
        blank_n_d     = active;
        pixel_x_d     = h_cnt;
        pixel_y_d     = v_cnt;
        frame_start_d = run && (h_cnt == '0) && (v_cnt == '0);
        frame_count_d = frame_end ? frame_count_q + 16'd1 : frame_count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= WAIT_FILL;
            rgb_q         <= '0;
            hold_q        <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            sync_n_q      <= (~HSYNC_POL) ^ (~VSYNC_POL);
            blank_n_q     <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            rgb_q         <= rgb_d;
            hold_q        <= hold_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            sync_n_q      <= sync_n_d;
            blank_n_q     <= blank_n_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign red         = rgb_q[RGB_W-1 -: COLOR_W];
    assign green       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign blue        = rgb_q[COLOR_W-1:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign sync_n      = sync_n_q;
    assign blank_n     = blank_n_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
    assign frame_count = frame_count_q;

endmodule
